// File: rtl/sobel_feeder_pkg.sv
// Shared definitions for the Sobel feeder slice.
//   PIXEL_WIDTH_OUT : grayscale pixel width on both the raster input and the
//                     window output.
//   pixel_t         : one pixel.
//   feeder_state_e  : feeder FSM states.
package sobel_feeder_pkg;

  localparam int PIXEL_WIDTH_OUT = 8;

  typedef logic [PIXEL_WIDTH_OUT-1:0] pixel_t;

  typedef enum logic [2:0] {
    WAIT_PX  = 3'd0,
    EMIT_TOP = 3'd1,
    EMIT_MID = 3'd2,
    EMIT_BOT = 3'd3,
    GAP1     = 3'd4,
    GAP2     = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/sobel_feeder_line_buffer.sv
// One image row of pixel storage with a single shared address per cycle.
// The read is asynchronous, so the old contents of a location can be
// forwarded in the same cycle that a new value is written there.
//   clk_i   : clock
//   we_i    : write enable, write lands on the rising edge
//   addr_i  : shared read/write address (column)
//   wdata_i : write data
//   rdata_o : current contents at addr_i
// Storage is deliberately not reset: the first two rows of every frame
// overwrite each location before it is ever read out.
module sobel_line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_feeder.sv
// Raster-to-window feeder for a 3x3 Sobel collector. Accepts one raster
// pixel at a time and, from the third row onward, emits the vertical
// column (top, mid, bottom) for the accepted column as three registered
// strobes. start_sobel_o frames each output row's strip, and every strip is
// followed by at least two idle cycles.
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   px_valid_i      : upstream pixel valid
//   in_px_i         : upstream pixel, raster order
//   px_ready_o      : feeder accepts a pixel this cycle
//   start_sobel_o   : high across one output row's strip
//   px_rdy_o        : out_px_o valid strobe
//   out_px_o        : pixel toward the window collector
//   frame_done_o    : one-cycle pulse after a frame's last pixel is emitted
//
// state    | meaning
// WAIT_PX  | ready for the next raster pixel
// EMIT_TOP | out_px_o = pixel two rows up
// EMIT_MID | out_px_o = pixel one row up
// EMIT_BOT | out_px_o = accepted pixel
// GAP1     | first idle cycle after a strip
// GAP2     | second idle cycle; frame_done_o pulses here on the final row
module sobel_feeder
  import sobel_feeder_pkg::*;
#(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic   clk_i,
  input  logic   nreset_i,
  input  logic   px_valid_i,
  input  pixel_t in_px_i,
  output logic   px_ready_o,
  output logic   start_sobel_o,
  output logic   px_rdy_o,
  output pixel_t out_px_o,
  output logic   frame_done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_EMIT  = ROW_W'(2);

  feeder_state_e    state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pixel_t           mid_q, mid_d;
  pixel_t           bot_q, bot_d;
  pixel_t           out_px_q, out_px_d;
  logic             px_rdy_q, px_rdy_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             last_col_q, last_col_d;
  logic             last_row_q, last_row_d;

  pixel_t lb_top_rd, lb_mid_rd;
  logic   xfer;

  assign xfer = px_valid_i && (state_q == WAIT_PX);

  // On a transfer the column shifts up one row: mid -> top, new pixel -> mid.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH_OUT)) u_lb_top (
    .clk_i   (clk_i),
    .we_i    (xfer),
    .addr_i  (col_q),
    .wdata_i (lb_mid_rd),
    .rdata_o (lb_top_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH_OUT)) u_lb_mid (
    .clk_i   (clk_i),
    .we_i    (xfer),
    .addr_i  (col_q),
    .wdata_i (in_px_i),
    .rdata_o (lb_mid_rd)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    mid_d      = mid_q;
    bot_d      = bot_q;
    out_px_d   = out_px_q;
    px_rdy_d   = 1'b0;
    start_d    = start_q;
    done_d     = 1'b0;
    last_col_d = last_col_q;
    last_row_d = last_row_q;

    unique case (state_q)
      WAIT_PX: begin
        if (xfer) begin
          mid_d      = lb_mid_rd;
          bot_d      = in_px_i;
          // Counters advance at acceptance; the flags remember where this
          // pixel sat for the end-of-strip and end-of-frame decisions.
          last_col_d = (col_q == COL_LAST);
          last_row_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (row_q >= ROW_EMIT) begin
            state_d  = EMIT_TOP;
            px_rdy_d = 1'b1;
            out_px_d = lb_top_rd;
            if (col_q == '0) begin
              start_d = 1'b1;
            end
          end
        end
      end
      EMIT_TOP: begin
        state_d  = EMIT_MID;
        px_rdy_d = 1'b1;
        out_px_d = mid_q;
      end
      EMIT_MID: begin
        state_d  = EMIT_BOT;
        px_rdy_d = 1'b1;
        out_px_d = bot_q;
      end
      EMIT_BOT: begin
        if (last_col_q) begin
          state_d = GAP1;
          start_d = 1'b0;
        end else begin
          state_d = WAIT_PX;
        end
      end
      GAP1: begin
        state_d = GAP2;
        done_d  = last_row_q;
      end
      GAP2: begin
        state_d = WAIT_PX;
      end
      default: begin
        state_d = WAIT_PX;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= WAIT_PX;
      col_q      <= '0;
      row_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      out_px_q   <= '0;
      px_rdy_q   <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      last_col_q <= 1'b0;
      last_row_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      mid_q      <= mid_d;
      bot_q      <= bot_d;
      out_px_q   <= out_px_d;
      px_rdy_q   <= px_rdy_d;
      start_q    <= start_d;
      done_q     <= done_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
    end
  end

  assign px_ready_o    = (state_q == WAIT_PX);
  assign start_sobel_o = start_q;
  assign px_rdy_o      = px_rdy_q;
  assign out_px_o      = out_px_q;
  assign frame_done_o  = done_q;

endmodule

// File: tb/tb_sobel_feeder.sv
module tb_sobel_feeder;
  import sobel_feeder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   nrst;
  logic   px_valid;
  pixel_t px_in;
  logic   sel4;

  logic   va, vb;
  logic   ready_a, ready_b, start_a, start_b, strb_a, strb_b, done_a, done_b;
  pixel_t out_a, out_b;

  assign va = px_valid & ~sel4;
  assign vb = px_valid & sel4;

  sobel_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
    .clk_i(clk), .nreset_i(nrst), .px_valid_i(va), .in_px_i(px_in),
    .px_ready_o(ready_a), .start_sobel_o(start_a), .px_rdy_o(strb_a),
    .out_px_o(out_a), .frame_done_o(done_a)
  );

  sobel_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .nreset_i(nrst), .px_valid_i(vb), .in_px_i(px_in),
    .px_ready_o(ready_b), .start_sobel_o(start_b), .px_rdy_o(strb_b),
    .out_px_o(out_b), .frame_done_o(done_b)
  );

  typedef struct {
    bit strb;
    bit start;
    bit done;
    bit ready;
  } trc_t;

  typedef struct {
    pixel_t px_in;
    pixel_t exp_out;
  } vec_t;

  trc_t   trace[$];
  pixel_t cap_a[$];
  pixel_t cap_b[$];
  pixel_t exp_q[$];
  int     done_a_cnt = 0;
  int     done_b_cnt = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      trc_t t;
      if (strb_a) cap_a.push_back(out_a);
      if (strb_b) cap_b.push_back(out_b);
      if (done_a) done_a_cnt++;
      if (done_b) done_b_cnt++;
      t.strb  = sel4 ? strb_b  : strb_a;
      t.start = sel4 ? start_b : start_a;
      t.done  = sel4 ? done_b  : done_a;
      t.ready = sel4 ? ready_b : ready_a;
      trace.push_back(t);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic drive_px(input pixel_t v);
    bit got = 1'b0;
    px_valid = 1'b1;
    px_in    = v;
    for (int b = 0; b < 40 && !got; b++) begin
      got = sel4 ? ready_b : ready_a;
      @(negedge clk);
    end
    check("px_accepted", int'(got), 1);
  endtask

  task automatic send_frame(input pixel_t f[$], input int max_gap);
    foreach (f[i]) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        px_valid = 1'b0;
        px_in    = pixel_t'($urandom);
        @(negedge clk);
      end
      drive_px(f[i]);
    end
    px_valid = 1'b0;
  endtask

  // Reference: every row r>=2 yields, per column c, the pixels at rows
  // r-2, r-1, r of that column.
  task automatic model_frame(input pixel_t f[$], input int w, input int h);
    for (int r = 2; r < h; r++)
      for (int c = 0; c < w; c++) begin
        exp_q.push_back(f[(r - 2) * w + c]);
        exp_q.push_back(f[(r - 1) * w + c]);
        exp_q.push_back(f[r * w + c]);
      end
  endtask

  function automatic int nth_strobe(input int base, input int n);
    int seen = 0;
    for (int i = base; i < trace.size(); i++)
      if (trace[i].strb) begin
        if (seen == n) return i;
        seen++;
      end
    return -1;
  endfunction

  function automatic int cap_at(input bit which_b, input int idx);
    if (which_b) return (idx < cap_b.size()) ? int'(cap_b[idx]) : -1;
    return (idx < cap_a.size()) ? int'(cap_a[idx]) : -1;
  endfunction

  initial begin
    vec_t   tbl[12];
    int     exp_ord[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    pixel_t f[$];
    pixel_t g[$];
    int     tb, cb, db, fi, li, l1, f2, bad;

    for (int i = 0; i < 12; i++) begin
      tbl[i].px_in   = pixel_t'(i);
      tbl[i].exp_out = pixel_t'(exp_ord[i]);
    end

    nrst = 1'b1; px_valid = 1'b0; px_in = '0; sel4 = 1'b0;
    #1 nrst = 1'b0;
    @(negedge clk);
    check("rst_strobe", int'(strb_a), 0);
    check("rst_start", int'(start_a), 0);
    check("rst_out", int'(out_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_ready", int'(ready_a), 1);
    check("rst_strobe_h4", int'(strb_b), 0);
    check("rst_out_h4", int'(out_b), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Directed ramp frame on the 4x3 instance, valid held continuously.
    tb = trace.size(); cb = cap_a.size(); db = done_a_cnt;
    f.delete();
    foreach (tbl[i]) f.push_back(tbl[i].px_in);
    send_frame(f, 0);
    repeat (12) @(negedge clk);
    check("ramp_count", cap_a.size() - cb, 12);
    foreach (tbl[i]) check($sformatf("ramp_px%0d", i), cap_at(1'b0, cb + i), int'(tbl[i].exp_out));
    check("ramp_frame_done_count", done_a_cnt - db, 1);
    fi = nth_strobe(tb, 0);
    li = nth_strobe(tb, 11);
    check("ramp_trace_bounds", int'(fi > tb && li > fi && li + 3 < trace.size()), 1);
    if (fi > tb && li > fi && li + 3 < trace.size()) begin
      check("ramp_start_before", int'(trace[fi - 1].start), 0);
      check("ramp_start_rise", int'(trace[fi].start), 1);
      bad = 0;
      for (int i = fi; i <= li; i++) if (!trace[i].start) bad++;
      check("ramp_start_held_lows", bad, 0);
      check("ramp_gap1_start", int'(trace[li + 1].start), 0);
      check("ramp_gap2_start", int'(trace[li + 2].start), 0);
      check("ramp_gap1_strobe", int'(trace[li + 1].strb), 0);
      check("ramp_done_in_gap2", int'(trace[li + 2].done), 1);
      bad = 0;
      for (int k = 0; k < 16; k++) if (trace[fi - 1 + k].ready != (k % 4 == 0)) bad++;
      check("ramp_ready_pattern_errs", bad, 0);
      check("ramp_gap1_ready", int'(trace[li + 1].ready), 0);
      check("ramp_gap2_ready", int'(trace[li + 2].ready), 0);
      check("ramp_ready_after_gap", int'(trace[li + 3].ready), 1);
    end

    // Two strips on the 4x4 instance.
    sel4 = 1'b1;
    @(negedge clk);
    tb = trace.size(); cb = cap_b.size(); db = done_b_cnt;
    f.delete();
    for (int i = 0; i < 16; i++) f.push_back(pixel_t'(i));
    exp_q.delete();
    model_frame(f, 4, 4);
    send_frame(f, 0);
    repeat (12) @(negedge clk);
    check("h4_count", cap_b.size() - cb, exp_q.size());
    foreach (exp_q[i]) check($sformatf("h4_px%0d", i), cap_at(1'b1, cb + i), int'(exp_q[i]));
    check("h4_strip2_first", cap_at(1'b1, cb + 12), 4);
    check("h4_strip2_second", cap_at(1'b1, cb + 13), 8);
    check("h4_strip2_third", cap_at(1'b1, cb + 14), 12);
    check("h4_frame_done_count", done_b_cnt - db, 1);
    l1 = nth_strobe(tb, 11);
    f2 = nth_strobe(tb, 12);
    check("h4_trace_bounds", int'(l1 > tb && f2 > l1 + 2), 1);
    if (l1 > tb && f2 > l1 + 2) begin
      check("h4_gap1_start", int'(trace[l1 + 1].start), 0);
      check("h4_gap2_start", int'(trace[l1 + 2].start), 0);
      check("h4_strip2_start_before", int'(trace[f2 - 1].start), 0);
      check("h4_strip2_start_rise", int'(trace[f2].start), 1);
    end
    sel4 = 1'b0;
    @(negedge clk);

    // Reset during EMIT_MID, then a fresh frame.
    f.delete();
    for (int i = 0; i < 9; i++) f.push_back(pixel_t'(i));
    send_frame(f, 0);
    check("pre_rst_top_strobe", int'(strb_a), 1);
    check("pre_rst_top_px", int'(out_a), 0);
    @(negedge clk);
    check("pre_rst_mid_px", int'(out_a), 4);
    nrst = 1'b0;
    #1;
    check("mid_rst_strobe", int'(strb_a), 0);
    check("mid_rst_start", int'(start_a), 0);
    check("mid_rst_out", int'(out_a), 0);
    check("mid_rst_ready", int'(ready_a), 1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    cb = cap_a.size(); db = done_a_cnt;
    f.delete();
    foreach (tbl[i]) f.push_back(tbl[i].px_in);
    send_frame(f, 0);
    repeat (12) @(negedge clk);
    check("post_rst_count", cap_a.size() - cb, 12);
    foreach (tbl[i]) check($sformatf("post_rst_px%0d", i), cap_at(1'b0, cb + i), int'(tbl[i].exp_out));
    check("post_rst_frame_done_count", done_a_cnt - db, 1);

    // Two random frames back to back with random valid gaps.
    cb = cap_a.size(); db = done_a_cnt;
    f.delete(); g.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) f.push_back(pixel_t'($urandom));
    for (int i = 0; i < 12; i++) g.push_back(pixel_t'($urandom));
    model_frame(f, 4, 3);
    model_frame(g, 4, 3);
    send_frame(f, 3);
    send_frame(g, 3);
    repeat (12) @(negedge clk);
    check("rand_count", cap_a.size() - cb, exp_q.size());
    foreach (exp_q[i]) check($sformatf("rand_px%0d", i), cap_at(1'b0, cb + i), int'(exp_q[i]));
    check("rand_frame_done_count", done_a_cnt - db, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_feeder.md
SOBEL_FEEDER -- requirements
Module: sobel_feeder

Interface
REQ-001 Parameter IMG_WIDTH, default 16, pixels per image row; legal range 3..64.
REQ-002 Parameter IMG_HEIGHT, default 16, rows per frame; legal range 3..64.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 nreset_i  input  1  asynchronous, active-low reset.
REQ-005 px_valid_i  input  1  upstream raster pixel valid.
REQ-006 in_px_i  input  PIXEL_WIDTH_OUT  upstream grayscale pixel, raster order (row-major, left to right).
REQ-007 px_ready_o  output  1  feeder can accept a pixel this cycle; transfer = px_valid_i & px_ready_o.
REQ-008 start_sobel_o  output  1  high for the whole window strip of one output row.
REQ-009 px_rdy_o  output  1  one-cycle strobe, out_px_o valid.
REQ-010 out_px_o  output  PIXEL_WIDTH_OUT  pixel toward the Sobel window collector.
REQ-011 frame_done_o  output  1  one-cycle pulse after last pixel of frame emitted.

Function
REQ-012 Feeder SHALL hold two line buffers (LB_TOP, LB_MID), IMG_WIDTH x PIXEL_WIDTH_OUT each, plus column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1).
REQ-013 FSM states SHALL be WAIT_PX, EMIT_TOP, EMIT_MID, EMIT_BOT, GAP1, GAP2.
REQ-014 px_ready_o SHALL be 1 only in WAIT_PX.
REQ-015 On transfer: latch top=LB_TOP[col], mid=LB_MID[col], bot=in_px_i; write LB_TOP[col]<=LB_MID[col], LB_MID[col]<=in_px_i.
REQ-016 Transfer with row<2: advance col/row, remain WAIT_PX, no output strobe.
REQ-017 Transfer with row>=2: next state EMIT_TOP; if col==0, start_sobel_o SHALL rise in the same cycle EMIT_TOP is entered.
REQ-018 EMIT_TOP/EMIT_MID/EMIT_BOT SHALL each drive px_rdy_o=1 with out_px_o=top/mid/bot respectively, one pixel per cycle, registered outputs.
REQ-019 Latency: pixel accepted at edge N -> top on out_px_o in cycle N+1, bot in N+3; sustained rate one input per 4 cycles.
REQ-020 First strip window is therefore 9 pixels (columns 0,1,2, top->bottom each); every later column adds exactly 3.
REQ-021 After EMIT_BOT: col<IMG_WIDTH-1 -> WAIT_PX; col==IMG_WIDTH-1 -> GAP1, start_sobel_o low from GAP1 onward.
REQ-022 GAP1, GAP2: px_rdy_o=0, start_sobel_o=0, px_ready_o=0 (guaranteed 2-cycle low gap between strips).
REQ-023 Counter wrap: col==IMG_WIDTH-1 -> col=0, row increments; row==IMG_HEIGHT-1 and col wraps -> row=0.
REQ-024 GAP2 of the final row SHALL pulse frame_done_o and return to WAIT_PX with row=0, col=0.
REQ-025 px_valid_i outside WAIT_PX SHALL be ignored (no transfer); data must be held upstream.
REQ-026 Line buffer contents are not cleared between frames; rows 0-1 of each frame overwrite them before use.

Reset
REQ-027 nreset_i low SHALL immediately force WAIT_PX, col=0, row=0, px_rdy_o=0, start_sobel_o=0, out_px_o=0, frame_done_o=0, top/mid/bot=0.
REQ-028 Reset mid-strip SHALL abort emission; next accepted pixel is treated as row 0, col 0.
REQ-029 Line buffer storage need not be reset.

Structure
REQ-030 PIXEL_WIDTH_OUT and the FSM state typedef SHALL come from the shared parameters.svh package/include.
REQ-031 One sub-module, sobel_line_buffer (single write/read port per cycle, IMG_WIDTH deep), instantiated twice.

Verification
REQ-032 IMG_WIDTH=4, IMG_HEIGHT=3, pixels 0..11 streamed back-to-back -> outputs 0,4,8,1,5,9,2,6,10,3,7,11; start_sobel_o high from first strobe to last, then low 2 cycles; frame_done_o one pulse.
REQ-033 Same config, px_valid_i held 1 continuously -> px_ready_o pattern 1,0,0,0 per pixel once row>=2; no pixel dropped or duplicated.
REQ-034 IMG_HEIGHT=4, ramp frame -> second strip starts with start_sobel_o rising after 2 low cycles, first outputs 4,8,12.
REQ-035 nreset_i pulsed during EMIT_MID -> px_rdy_o and start_sobel_o 0 immediately; fresh 12-pixel frame reproduces REQ-032 sequence.
REQ-036 Two consecutive frames with random valid gaps -> second frame output identical to standalone reference model output.
